// File: rtl/vec_sum_pkg.sv
// Shared types and sizing helpers for the vec_sum_master IOb read-accumulate-write engine.
package vec_sum_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WB_DRAIN,
    DONE
  } state_t;

  localparam int N_ELEM_DEF = 8;

  // Element counter must be able to hold N_ELEM itself after the final increment.
  function automatic int CNT_W(input int n_elem);
    return (n_elem < 1) ? 1 : $clog2(n_elem + 1);
  endfunction

endpackage

// File: rtl/vec_sum_master_if.sv
// IOb native request/response bus plus the cache write-through-buffer status line.
interface vec_sum_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic                  iob_valid_o;
  logic [ADDR_W-1:0]     iob_addr_o;
  logic [DATA_W-1:0]     iob_wdata_o;
  logic [DATA_W/8-1:0]   iob_wstrb_o;
  logic [DATA_W-1:0]     iob_rdata_i;
  logic                  iob_rvalid_i;
  logic                  iob_ready_i;
  logic                  wtb_empty_i;

  modport master (
    output iob_valid_o,
    output iob_addr_o,
    output iob_wdata_o,
    output iob_wstrb_o,
    input  iob_rdata_i,
    input  iob_rvalid_i,
    input  iob_ready_i,
    input  wtb_empty_i
  );

  modport slave (
    input  iob_valid_o,
    input  iob_addr_o,
    input  iob_wdata_o,
    input  iob_wstrb_o,
    output iob_rdata_i,
    output iob_rvalid_i,
    output iob_ready_i,
    output wtb_empty_i
  );

endinterface

// File: rtl/vec_sum_acc.sv
// Signed accumulator with synchronous clear and enable; the add wraps in two's complement.
module vec_sum_acc #(
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] acc_o,
  output logic signed [DATA_W-1:0] acc_nxt_o
);

  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] acc_d;

  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  assign acc_nxt_o = wrap_add(acc_q, din_i);
  assign acc_o     = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_nxt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/vec_sum_master.sv
// IOb master: reads N_ELEM consecutive words, sums them, writes the sum to dst and
// waits for the cache write-through buffer to drain before pulsing done.
module vec_sum_master
  import vec_sum_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int N_ELEM = N_ELEM_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] sum_o,
  vec_sum_master_if.master  iob
);

  localparam int CNT_WIDTH = CNT_W(N_ELEM);
  localparam int STRB_W    = DATA_W / 8;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_ELEM - 1);

  state_t                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]        src_q, src_d;
  logic [ADDR_W-1:0]        dst_q, dst_d;
  logic                     valid_q, valid_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [DATA_W-1:0]        sum_q, sum_d;

  logic                     acc_clr;
  logic                     acc_en;
  logic signed [DATA_W-1:0] acc_val;
  logic signed [DATA_W-1:0] acc_nxt;

  vec_sum_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (acc_clr),
    .en_i      (acc_en),
    .din_i     ($signed(iob.iob_rdata_i)),
    .acc_o     (acc_val),
    .acc_nxt_o (acc_nxt)
  );

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  // Request fields are computed one cycle ahead from the next state, so the bus
  // outputs are pure flops and stay frozen while a request waits for ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          cnt_d   = '0;
          acc_clr = 1'b1;
          valid_d = 1'b1;
          addr_d  = src_addr_i;
          wstrb_d = '0;
          busy_d  = 1'b1;
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        if (iob.iob_ready_i) begin
          valid_d = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (iob.iob_rvalid_i) begin
          acc_en = 1'b1;
          cnt_d  = cnt_inc;
          valid_d = 1'b1;
          if (cnt_q == LAST_IDX) begin
            addr_d  = dst_q;
            wdata_d = acc_nxt;
            wstrb_d = '1;
            state_d = WR_REQ;
          end else begin
            addr_d  = src_q + ADDR_W'(cnt_inc);
            state_d = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (iob.iob_ready_i) begin
          valid_d = 1'b0;
          wstrb_d = '0;
          state_d = WB_DRAIN;
        end
      end

      WB_DRAIN: begin
        if (iob.wtb_empty_i) begin
          done_d  = 1'b1;
          sum_d   = acc_val;
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        state_d = IDLE;
      end

      default: begin
        valid_d = 1'b0;
        wstrb_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
    end
  end

  // Captured addresses are only consumed after a start, so they need no reset.
  always_ff @(posedge clk_i) begin
    src_q <= src_d;
    dst_q <= dst_d;
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sum_o           = sum_q;
  assign iob.iob_valid_o = valid_q;
  assign iob.iob_addr_o  = addr_q;
  assign iob.iob_wdata_o = wdata_q;
  assign iob.iob_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_vec_sum_master.sv
// Bench for vec_sum_master: behavioural IOb memory slave with configurable stalls and
// a plain-arithmetic reference for sums, request sequence and completion cycle.
module tb_vec_sum_master;
  import vec_sum_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int N      = 8;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] src_addr_i = '0;
  logic [ADDR_W-1:0] dst_addr_i = '0;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] sum_o;

  vec_sum_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) iob ();

  vec_sum_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_ELEM (N)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sum_o      (sum_o),
    .iob        (iob)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]       mem [MEMSZ];
  int                n_checks = 0;
  int                n_pass = 0;

  int                cfg_rd_delay = 1;
  int                cfg_stall_rd0 = 0;
  int                cfg_stall_wr = 0;
  int                cfg_wtb_hold = 0;

  logic [ADDR_W-1:0] log_addr [$];
  logic [3:0]        log_wstrb [$];
  logic [31:0]       log_wdata [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory slave: decisions at the falling edge, seen by the DUT at the next rising edge.
  initial begin
    int rd_cd;
    int wtb_cd;
    int stall_cnt;
    int need;
    logic pv, pr;
    logic [ADDR_W-1:0] pa, ra;
    logic [31:0] pd;
    logic [3:0] ps;
    rd_cd = 0; wtb_cd = 0; stall_cnt = 0; need = 0;
    pv = 1'b0; pr = 1'b0; pa = '0; ra = '0; pd = '0; ps = '0;
    iob.iob_ready_i  = 1'b0;
    iob.iob_rvalid_i = 1'b0;
    iob.iob_rdata_i  = '0;
    iob.wtb_empty_i  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        rd_cd = 0; wtb_cd = 0; stall_cnt = 0; pv = 1'b0; pr = 1'b0;
        iob.iob_ready_i  = 1'b0;
        iob.iob_rvalid_i = 1'b0;
        iob.wtb_empty_i  = 1'b1;
      end else begin
        if (pv && pr) begin
          log_addr.push_back(pa);
          log_wstrb.push_back(ps);
          log_wdata.push_back(pd);
          if (ps == 4'h0) begin
            rd_cd = cfg_rd_delay;
            ra = pa;
          end else begin
            mem[pa] = pd;
            wtb_cd = cfg_wtb_hold;
          end
          stall_cnt = 0;
        end else if (pv && !pr && iob.iob_valid_o) begin
          chk("stall_addr", 64'(iob.iob_addr_o), 64'(pa));
          chk("stall_wstrb", 64'(iob.iob_wstrb_o), 64'(ps));
          if (ps != 4'h0) chk("stall_wdata", 64'(iob.iob_wdata_o), 64'(pd));
        end
        iob.iob_rvalid_i = 1'b0;
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin
            iob.iob_rvalid_i = 1'b1;
            iob.iob_rdata_i  = mem[ra];
          end
        end
        if (wtb_cd > 0) begin
          iob.wtb_empty_i = 1'b0;
          wtb_cd--;
        end else begin
          iob.wtb_empty_i = 1'b1;
        end
        need = (iob.iob_wstrb_o != 4'h0) ? cfg_stall_wr :
               ((log_addr.size() == 0) ? cfg_stall_rd0 : 0);
        if (iob.iob_valid_o && stall_cnt < need) begin
          iob.iob_ready_i = 1'b0;
          stall_cnt++;
        end else begin
          iob.iob_ready_i = iob.iob_valid_o;
        end
        pv = iob.iob_valid_o;
        pr = iob.iob_ready_i;
        pa = iob.iob_addr_o;
        pd = iob.iob_wdata_o;
        ps = iob.iob_wstrb_o;
      end
    end
  end

  task automatic run_case(input string tag, input logic [ADDR_W-1:0] src,
                          input logic [ADDR_W-1:0] dst, input int rdd, input int s0,
                          input int sw, input int wh, input int inj);
    logic [31:0]       exp_sum;
    logic [ADDR_W-1:0] a;
    int                lat;
    int                c0;
    int                k;
    exp_sum = '0;
    for (int i = 0; i < N; i++) begin
      a = src + ADDR_W'(i);
      exp_sum = exp_sum + mem[a];
    end
    lat = 1 + N * (1 + rdd) + s0 + (1 + sw) + (wh + 1);
    cfg_rd_delay = rdd; cfg_stall_rd0 = s0; cfg_stall_wr = sw; cfg_wtb_hold = wh;
    log_addr.delete(); log_wstrb.delete(); log_wdata.delete();

    @(negedge clk);
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst;
    @(negedge clk);
    c0 = cyc;
    start_i = 1'b0;
    src_addr_i = src ^ 12'h5A5;
    dst_addr_i = dst ^ 12'h3C3;
    chk({tag, "_busy_first"}, 64'(busy_o), 64'(1));
    chk({tag, "_valid_first"}, 64'(iob.iob_valid_o), 64'(1));
    chk({tag, "_addr_first"}, 64'(iob.iob_addr_o), 64'(src));

    k = 0;
    while (!done_o && k < 400) begin
      start_i = (k == inj);
      @(negedge clk);
      k++;
    end
    start_i = 1'b0;
    chk({tag, "_done_seen"}, 64'(done_o), 64'(1));
    chk({tag, "_done_cycle"}, 64'(cyc - c0), 64'(lat - 1));
    chk({tag, "_sum"}, 64'(sum_o), 64'(exp_sum));
    chk({tag, "_busy_at_done"}, 64'(busy_o), 64'(1));
    chk({tag, "_nreq"}, 64'(log_addr.size()), 64'(N + 1));
    for (int i = 0; i < N && i < log_addr.size(); i++) begin
      a = src + ADDR_W'(i);
      chk({tag, "_rd_addr"}, 64'(log_addr[i]), 64'(a));
      chk({tag, "_rd_wstrb"}, 64'(log_wstrb[i]), 64'(0));
    end
    if (log_addr.size() > N) begin
      chk({tag, "_wr_addr"}, 64'(log_addr[N]), 64'(dst));
      chk({tag, "_wr_wstrb"}, 64'(log_wstrb[N]), 64'(4'hF));
      chk({tag, "_wr_data"}, 64'(log_wdata[N]), 64'(exp_sum));
    end
    chk({tag, "_mem_dst"}, 64'(mem[dst]), 64'(exp_sum));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done_o), 64'(0));
    chk({tag, "_busy_after"}, 64'(busy_o), 64'(0));
    chk({tag, "_valid_idle"}, 64'(iob.iob_valid_o), 64'(0));
    chk({tag, "_sum_held"}, 64'(sum_o), 64'(exp_sum));
  endtask

  initial begin
    int k;
    logic [ADDR_W-1:0] rs, rd;
    for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(iob.iob_valid_o), 64'(0));
    chk("rst_addr", 64'(iob.iob_addr_o), 64'(0));
    chk("rst_wdata", 64'(iob.iob_wdata_o), 64'(0));
    chk("rst_wstrb", 64'(iob.iob_wstrb_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_sum", 64'(sum_o), 64'(0));
    rst_i = 1'b0;

    for (int i = 0; i < N; i++) mem[12'h010 + i] = 32'(i + 1);
    run_case("base", 12'h010, 12'h020, 1, 0, 0, 0, -1);
    chk("base_sum36", 64'(sum_o), 64'(36));

    for (int i = 0; i < N; i++) mem[12'h010 + i] = -32'(i + 1);
    run_case("neg", 12'h010, 12'h020, 1, 0, 0, 0, -1);
    chk("neg_sum", 64'(sum_o), 64'(32'hFFFF_FFDC));

    for (int i = 0; i < N; i++) mem[12'h010 + i] = 32'h7FFF_FFFF;
    run_case("wrap", 12'h010, 12'h020, 1, 0, 0, 0, -1);
    chk("wrap_sum", 64'(sum_o), 64'(32'hFFFF_FFF8));

    for (int i = 0; i < N; i++) mem[12'h010 + i] = 32'(i + 1);
    run_case("stall", 12'h010, 12'h020, 4, 3, 3, 0, -1);

    run_case("addrwrap", 12'hFFD, 12'h100, 1, 0, 0, 5, -1);
    run_case("inject", 12'h040, 12'h043, 2, 1, 1, 1, 5);

    // Reset while element 4 is outstanding, then a clean rerun.
    cfg_rd_delay = 4; cfg_stall_rd0 = 0; cfg_stall_wr = 0; cfg_wtb_hold = 0;
    log_addr.delete(); log_wstrb.delete(); log_wdata.delete();
    @(negedge clk);
    start_i = 1'b1; src_addr_i = 12'h200; dst_addr_i = 12'h300;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (log_addr.size() < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_el4", 64'(log_addr.size()), 64'(5));
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(iob.iob_valid_o), 64'(0));
    chk("mid_rst_wstrb", 64'(iob.iob_wstrb_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_done", 64'(done_o), 64'(0));
    chk("mid_rst_sum", 64'(sum_o), 64'(0));
    @(negedge clk);
    rst_i = 1'b0;
    run_case("after_rst", 12'h200, 12'h300, 1, 0, 0, 0, -1);

    for (int r = 0; r < 3; r++) begin
      rs = ADDR_W'($urandom);
      rd = ADDR_W'($urandom);
      run_case("rand", rs, rd, 1 + int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
